// File: rtl/sc_decoder_et_if.sv
// sc_decoder_et_if: bundles the beat-input and result-output handshakes of the
// stochastic-to-binary decoder.
//   in_valid/in_ready/Xs/in_last : one stream bit per channel per beat
//   out_valid/out_ready          : result handshake
//   Ys/out_len/len_err           : normalized per-channel results and stream length
// Modports:
//   slave  - the decoder (consumes beats, produces results)
//   master - the environment (produces beats, consumes results)
interface sc_decoder_et_if #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 8
);
  logic                              in_valid;
  logic                              in_ready;
  logic [NUM_INPUTS-1:0]             Xs;
  logic                              in_last;
  logic                              out_valid;
  logic                              out_ready;
  logic [(WIDTH+1)*NUM_INPUTS-1:0]   Ys;
  logic [WIDTH:0]                    out_len;
  logic                              len_err;

  modport slave (
    input  in_valid, Xs, in_last, out_ready,
    output in_ready, out_valid, Ys, out_len, len_err
  );

  modport master (
    output in_valid, Xs, in_last, out_ready,
    input  in_ready, out_valid, Ys, out_len, len_err
  );
endinterface

// File: rtl/sc_decoder_et.sv
// sc_decoder_et: multi-channel stochastic-to-binary decoder with early termination.
// Counts ones per channel over a stream of beats; at end of stream (in_last or
// 2^WIDTH beats) the counts are scaled to the full 2^WIDTH range and held until
// the consumer takes them.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - sc_decoder_et_if.slave (beat input and result output handshakes)
module sc_decoder_et #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 8
) (
  input  logic              clk,
  input  logic              rst,
  sc_decoder_et_if.slave    bus
);

  localparam logic [WIDTH:0] ZERO     = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH:0] ONE      = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] FULL_LEN = {1'b1, {WIDTH{1'b0}}};

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // True when len is exactly 2^k for some 0 <= k <= WIDTH.
  function automatic logic len_is_pow2(input logic [WIDTH:0] len);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k <= WIDTH; k++) begin
      if (len == (ONE << k)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  // Scale a count of ones over a 2^k-beat stream up to the 2^WIDTH scale;
  // non-power-of-two lengths pass the raw count through.
  function automatic logic [WIDTH:0] normalize(input logic [WIDTH:0] cnt,
                                               input logic [WIDTH:0] len);
    logic [WIDTH:0] res;
    res = cnt;
    for (int k = 0; k <= WIDTH; k++) begin
      if (len == (ONE << k)) begin
        res = cnt << (WIDTH - k);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t                               state_q, state_d;
  logic [NUM_INPUTS-1:0][WIDTH:0]       cnt_q, cnt_d, cnt_inc;
  logic [WIDTH:0]                       len_q, len_d, len_inc;
  logic [(WIDTH+1)*NUM_INPUTS-1:0]      ys_q, ys_d;
  logic [WIDTH:0]                       out_len_q, out_len_d;
  logic                                 len_err_q, len_err_d;
  logic                                 out_valid_q, out_valid_d;
  logic                                 in_ready_q, in_ready_d;
  logic                                 beat;

  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.Ys        = ys_q;
  assign bus.out_len   = out_len_q;
  assign bus.len_err   = len_err_q;

  // Next-state, counter and result computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    ys_d        = ys_q;
    out_len_d   = out_len_q;
    len_err_d   = len_err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    // Counts including the current beat, so the terminating beat is part
    // of the normalized result.
    len_inc = len_q + ONE;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cnt_inc[i] = cnt_q[i] + {{WIDTH{1'b0}}, bus.Xs[i]};
    end
    beat = bus.in_valid && (state_q == ST_ACCUM);

    case (state_q)
      ST_ACCUM: begin
        if (beat) begin
          cnt_d = cnt_inc;
          len_d = len_inc;
          // Explicit and implicit last on the same beat form one end event.
          if (bus.in_last || (len_inc == FULL_LEN)) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
              ys_d[i*(WIDTH+1) +: WIDTH+1] = normalize(cnt_inc[i], len_inc);
            end
            out_len_d   = len_inc;
            len_err_d   = ~len_is_pow2(len_inc);
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        // Results stay in ys_q after the handshake; only the counters clear.
        if (bus.out_ready) begin
          cnt_d       = '{default: ZERO};
          len_d       = ZERO;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_ACCUM;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        cnt_d       = '{default: ZERO};
        len_d       = ZERO;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_ACCUM;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      cnt_q       <= '{default: ZERO};
      len_q       <= ZERO;
      ys_q        <= {((WIDTH+1)*NUM_INPUTS){1'b0}};
      out_len_q   <= ZERO;
      len_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ys_q        <= ys_d;
      out_len_q   <= out_len_d;
      len_err_q   <= len_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule
